pixie_line_fetcher: RTL

//  Parametrised successor to the fixed CDP1861 display DMA path. Fetches one display line of bytes from RAM

---
 rtl/pixie_line_fetcher.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pixie_line_fetcher.sv
// Fetches one display line from RAM into a back buffer and shifts the front buffer out as 1bpp pixels.
// Latency: first ram_rd 1 clk after start_frame (2 clks when aborting a running frame); first pixel 1 clk after line_req.
// No backpressure: line_req/pix_ce pace the output; a line that is not ready in time shows blank and sets underrun.
module pixie_line_fetcher #(
  parameter int BYTES_PER_LINE = 8,
  parameter int LINES          = 32,
  parameter int LINE_REPEAT    = 4,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_frame,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              line_req,
  input  logic              pix_ce,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_a,
  input  logic [7:0]        ram_q,
  output logic              dmao,
  output logic              pix_out,
  output logic              pix_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun
);

  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int RW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
  localparam int FW = $clog2(BYTES_PER_LINE + 1);
  localparam int BW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

  localparam logic [LW-1:0]     LAST_LINE = LW'(LINES - 1);
  localparam logic [RW-1:0]     LAST_REP  = RW'(LINE_REPEAT - 1);
  localparam logic [FW-1:0]     FETCH_END = FW'(BYTES_PER_LINE);
  localparam logic [BW-1:0]     LAST_BYTE = BW'(BYTES_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(BYTES_PER_LINE);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] line_ptr;
  logic [LW-1:0]     line_cnt;
  logic [RW-1:0]     rep_cnt;
  logic [FW-1:0]     fetch_idx;
  logic              fetch_gap;   // one dead clk after an abort so ram_rd visibly drops
  logic [BW-1:0]     cap_idx;
  logic [7:0]        back  [BYTES_PER_LINE];
  logic [7:0]        front [BYTES_PER_LINE];
  logic              back_valid;

  logic              shifting;
  logic [BW-1:0]     byte_idx;
  logic [2:0]        bit_idx;

  logic              req_ok;      // line_req honoured: frame running, no start_frame this clk
  logic              req_scan;    // line_req that advances the scanline counters
  logic              new_line;
  logic              last_scan;
  logic              take_back;
  logic              refetch;
  logic              fetch_last;
  logic              capture;
  logic              shift_end;
  logic              drain_done;

  assign new_line   = (rep_cnt == '0);
  assign last_scan  = (line_cnt == LAST_LINE) && (rep_cnt == LAST_REP);
  assign req_ok     = line_req && !start_frame && (state != IDLE);
  assign req_scan   = req_ok && (state != DRAIN);
  assign take_back  = req_scan && new_line && back_valid;
  // The line being consumed is the last RAM line when line_cnt hits the limit.
  assign refetch    = take_back && (line_cnt != LAST_LINE);
  assign fetch_last = (state == FETCH) && !fetch_gap && (fetch_idx == FETCH_END);
  assign capture    = (state == FETCH) && !fetch_gap && (fetch_idx != '0);
  assign cap_idx    = BW'(fetch_idx - FW'(1));
  assign shift_end  = shifting && pix_ce && (byte_idx == LAST_BYTE) && (bit_idx == 3'd7);
  assign drain_done = (state == DRAIN) && shift_end && !line_req && !start_frame;

  assign ram_a      = line_ptr + ADDR_W'(fetch_idx);
  assign pix_valid  = shifting;
  assign pix_out    = shifting & front[byte_idx][3'd7 - bit_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and fetch-side strobes.
  always_comb begin
    state_nxt = state;
    ram_rd    = 1'b0;
    dmao      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_frame) state_nxt = FETCH;
      end
      FETCH: begin
        ram_rd = !fetch_gap && (fetch_idx != FETCH_END);
        dmao   = !fetch_gap;
        if (start_frame)             state_nxt = FETCH;
        else if (req_scan && last_scan) state_nxt = DRAIN;
        else if (fetch_last)         state_nxt = WAIT;
      end
      WAIT: begin
        if (start_frame)             state_nxt = FETCH;
        else if (req_scan && last_scan) state_nxt = DRAIN;
        else if (refetch)            state_nxt = FETCH;
      end
      DRAIN: begin
        if (start_frame)     state_nxt = FETCH;
        else if (drain_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch side: read index, capture one clk behind the read, back buffer ownership.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_ptr   <= '0;
      fetch_idx  <= '0;
      fetch_gap  <= 1'b0;
      back_valid <= 1'b0;
      back       <= '{default: '0};
    end else if (start_frame) begin
      line_ptr   <= base_addr;
      fetch_idx  <= '0;
      fetch_gap  <= (state != IDLE);
      back_valid <= 1'b0;
    end else begin
      if (state == FETCH) begin
        fetch_gap <= 1'b0;
        if (!fetch_gap) begin
          if (capture) back[cap_idx] <= ram_q;
          if (fetch_last) begin
            back_valid <= 1'b1;
            line_ptr   <= line_ptr + LINE_STEP;
            fetch_idx  <= '0;
          end else begin
            fetch_idx  <= fetch_idx + FW'(1);
          end
        end
      end else begin
        fetch_idx <= '0;
      end
      if (take_back) back_valid <= 1'b0;
    end
  end

  // Scan side: scanline counters, front buffer swap, pixel shifter, status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt   <= '0;
      rep_cnt    <= '0;
      underrun   <= 1'b0;
      front      <= '{default: '0};
      shifting   <= 1'b0;
      byte_idx   <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= drain_done;
      if (start_frame) begin
        line_cnt <= '0;
        rep_cnt  <= '0;
        underrun <= 1'b0;
        front    <= '{default: '0};
        shifting <= 1'b0;
        byte_idx <= '0;
        bit_idx  <= '0;
      end else begin
        if (req_scan) begin
          if (new_line) begin
            if (back_valid) begin
              front <= back;
            end else begin
              front    <= '{default: '0};
              underrun <= 1'b1;
            end
          end
          if (rep_cnt == LAST_REP) begin
            rep_cnt  <= '0;
            line_cnt <= (line_cnt == LAST_LINE) ? '0 : line_cnt + LW'(1);
          end else begin
            rep_cnt  <= rep_cnt + RW'(1);
          end
        end
        if (req_ok) begin
          shifting <= 1'b1;
          byte_idx <= '0;
          bit_idx  <= '0;
        end else if (shifting && pix_ce) begin
          if (shift_end) shifting <= 1'b0;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + BW'(1);
        end
      end
    end
  end

endmodule
